// File: rtl/anton_neopixel_sequencer.sv
// NeoPixel frame sequencer: walks pixel/bit/slot indices for a WS2812-style line, then holds a line-low gap between frames.
// Latency: start request seen in IDLE -> TRANSMIT on the next cycle; every output is registered.
// Backpressure: none; regCtrlRun low aborts the current frame and restarts the gap. Optional: ANTON_NEOPIXEL_FRAME_COUNT_EN adds frameCount.

`ifndef CLOG2
`define CLOG2(x) $clog2(x)
`endif
`ifndef BUFFER_END_DEFAULT
`define BUFFER_END_DEFAULT 255
`endif
`ifndef ENUM_STATE_TRANSMIT
`define ENUM_STATE_TRANSMIT 1'b1
`endif
`ifndef ENUM_STATE_RESET
`define ENUM_STATE_RESET 1'b0
`endif

module anton_neopixel_sequencer #(
    parameter int  BUFFER_END  = `BUFFER_END_DEFAULT,
    parameter int  RESET_DELAY = 400,
    localparam int BUFFER_BITS = `CLOG2(BUFFER_END + 1)
) (
    input  logic                   clk7mhz,
    input  logic                   reset,
    input  logic                   regCtrlRun,
    input  logic                   regCtrlLoop,
    input  logic                   regCtrl32bit,
    input  logic                   regCtrlStart,
    input  logic [BUFFER_BITS-1:0] regPixelMax,
    output logic                   state,
    output logic [BUFFER_BITS-1:0] pixelIndex,
    output logic [4:0]             pixelBitIndex,
    output logic [2:0]             bitPatternIndex,
`ifdef ANTON_NEOPIXEL_FRAME_COUNT_EN
    output logic [15:0]            frameCount,
`endif
    output logic                   streamSyncOf
);

    localparam int GAP_BITS = `CLOG2(RESET_DELAY);

    typedef enum logic [1:0] {
        S_GAP  = 2'd0,
        S_IDLE = 2'd1,
        S_TX   = 2'd2
    } fsm_t;

    fsm_t                   fsm_q, fsm_d;
    logic [GAP_BITS-1:0]    gap_q, gap_d;
    logic [BUFFER_BITS-1:0] pix_q, pix_d;
    logic [4:0]             bit_q, bit_d;
    logic [2:0]             slot_q, slot_d;
    logic                   sync_q, sync_d;
    logic                   state_q, state_d;
    logic [BUFFER_BITS-1:0] pix_max_c;
    logic                   last_pix;

    // Clamp the software pixel limit to the buffer and decide whether the current pixel is the frame's last
    always_comb begin
        pix_max_c = (regPixelMax > BUFFER_BITS'(BUFFER_END)) ? BUFFER_BITS'(BUFFER_END) : regPixelMax;
        if (regCtrl32bit) begin
            last_pix = (pix_q[BUFFER_BITS-1:2] == pix_max_c[BUFFER_BITS-1:2]);
        end else begin
            last_pix = (pix_q == pix_max_c);
        end
    end

    // Next-state logic: gap counting, frame start decisions and the slot/bit/pixel walk
    always_comb begin
        fsm_d  = fsm_q;
        gap_d  = gap_q;
        pix_d  = pix_q;
        bit_d  = bit_q;
        slot_d = slot_q;
        sync_d = 1'b0;
        if (!regCtrlRun) begin
            // Abort: the gap always restarts from zero so a full line-low period precedes the next frame
            fsm_d  = S_GAP;
            gap_d  = '0;
            pix_d  = '0;
            bit_d  = 5'd23;
            slot_d = 3'd0;
        end else begin
            case (fsm_q)
                S_GAP: begin
                    if (gap_q == GAP_BITS'(RESET_DELAY - 1)) begin
                        fsm_d  = regCtrlLoop ? S_TX : S_IDLE;
                        pix_d  = '0;
                        bit_d  = 5'd23;
                        slot_d = 3'd0;
                    end else begin
                        gap_d = gap_q + 1'b1;
                    end
                end
                S_IDLE: begin
                    if (regCtrlStart || regCtrlLoop) begin
                        fsm_d  = S_TX;
                        pix_d  = '0;
                        bit_d  = 5'd23;
                        slot_d = 3'd0;
                    end
                end
                S_TX: begin
                    slot_d = slot_q + 3'd1;
                    // Raise the pulse one cycle early so the registered flag lines up with the final slot
                    sync_d = (slot_q == 3'd6) && (bit_q == 5'd0) && last_pix;
                    if (slot_q == 3'd7) begin
                        if (bit_q == 5'd0) begin
                            bit_d = 5'd23;
                            if (last_pix) begin
                                fsm_d = S_GAP;
                                gap_d = '0;
                                pix_d = '0;
                            end else begin
                                pix_d = pix_q + (regCtrl32bit ? BUFFER_BITS'(4) : BUFFER_BITS'(1));
                            end
                        end else begin
                            bit_d = bit_q - 5'd1;
                        end
                    end
                end
                default: begin
                    fsm_d  = S_GAP;
                    gap_d  = '0;
                    pix_d  = '0;
                    bit_d  = 5'd23;
                    slot_d = 3'd0;
                end
            endcase
        end
        state_d = (fsm_d == S_TX) ? `ENUM_STATE_TRANSMIT : `ENUM_STATE_RESET;
    end

    // State registers; reset wins over every control input
    always_ff @(posedge clk7mhz) begin
        if (reset) begin
            fsm_q   <= S_GAP;
            gap_q   <= '0;
            pix_q   <= '0;
            bit_q   <= 5'd23;
            slot_q  <= 3'd0;
            sync_q  <= 1'b0;
            state_q <= `ENUM_STATE_RESET;
        end else begin
            fsm_q   <= fsm_d;
            gap_q   <= gap_d;
            pix_q   <= pix_d;
            bit_q   <= bit_d;
            slot_q  <= slot_d;
            sync_q  <= sync_d;
            state_q <= state_d;
        end
    end

    assign state           = state_q;
    assign pixelIndex      = pix_q;
    assign pixelBitIndex   = bit_q;
    assign bitPatternIndex = slot_q;
    assign streamSyncOf    = sync_q;

`ifdef ANTON_NEOPIXEL_FRAME_COUNT_EN
    logic [15:0] fc_q, fc_d;

    // Completed-frame counter, bumped once per end-of-frame pulse and wrapping at 16 bits
    always_comb begin
        fc_d = fc_q + {15'd0, sync_q};
    end

    // Frame counter register
    always_ff @(posedge clk7mhz) begin
        if (reset) begin
            fc_q <= '0;
        end else begin
            fc_q <= fc_d;
        end
    end

    assign frameCount = fc_q;
`endif

endmodule

// File: doc/anton_neopixel_sequencer.md
ANTON_NEOPIXEL_SEQUENCER -- requirements
Module: anton_neopixel_sequencer

Interface
REQ-001 Parameter BUFFER_END, default `BUFFER_END_DEFAULT, index of the last pixel-buffer byte; BUFFER_BITS = `CLOG2(BUFFER_END+1).
REQ-002 Parameter RESET_DELAY, default 400, line-low cycles between frames (>50 us at 7 MHz); minimum 2.
REQ-003 clk7mhz  input  1  sole clock, all state on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 regCtrlRun  input  1  enable; low aborts any frame.
REQ-006 regCtrlLoop  input  1  auto-restart the next frame after each reset gap.
REQ-007 regCtrl32bit  input  1  32-bit pixel mode (4 buffer bytes per pixel).
REQ-008 regCtrlStart  input  1  one-cycle request for a single frame.
REQ-009 regPixelMax  input  BUFFER_BITS  index of the last pixel to send, clamped to BUFFER_END.
REQ-010 state  output  1  `ENUM_STATE_TRANSMIT while sending bits, `ENUM_STATE_RESET otherwise.
REQ-011 pixelIndex  output  BUFFER_BITS  current pixel buffer index.
REQ-012 pixelBitIndex  output  5  current colour bit, 23 down to 0.
REQ-013 bitPatternIndex  output  3  current slot within a bit pattern, 0..7.
REQ-014 streamSyncOf  output  1  one-cycle pulse on the cycle the last slot of a frame is sent.

Function
REQ-015 Internal states: GAP (line low, counting), IDLE (gap done, waiting), TRANSMIT; `state` is `ENUM_STATE_TRANSMIT only in TRANSMIT.
REQ-016 GAP: a gap counter of width `CLOG2(RESET_DELAY) increments each cycle; at RESET_DELAY-1 the block enters IDLE, or enters TRANSMIT if regCtrlRun && regCtrlLoop.
REQ-017 IDLE: enter TRANSMIT when regCtrlRun && (regCtrlStart || regCtrlLoop); regCtrlStart seen in GAP or TRANSMIT is ignored, not queued.
REQ-018 Entry to TRANSMIT loads pixelIndex=0, pixelBitIndex=23, bitPatternIndex=0.
REQ-019 TRANSMIT: bitPatternIndex increments every cycle, wrapping 7->0.
REQ-020 On the 7->0 wrap pixelBitIndex decrements; on pixelBitIndex 0 it reloads 23 and pixelIndex advances by 1 (8-bit mode) or 4 (32-bit mode).
REQ-021 Last pixel: 8-bit mode pixelIndex == clamped regPixelMax; 32-bit mode pixelIndex[BUFFER_BITS-1:2] == clamped regPixelMax[BUFFER_BITS-1:2].
REQ-022 On slot 7, bit 0 of the last pixel: streamSyncOf=1 that cycle, next cycle GAP with the gap counter at 0 and pixelIndex, pixelBitIndex, bitPatternIndex at 0, 23, 0.
REQ-023 Frame length is exactly (pixels x 24 x 8) TRANSMIT cycles; pixels = clamped regPixelMax+1 (8-bit) or clamped regPixelMax/4+1 (32-bit).
REQ-024 regCtrlRun low in any state forces GAP next cycle with the gap counter at 0, no streamSyncOf; a full gap is always served before the next frame.
REQ-025 regPixelMax, regCtrl32bit and regCtrlLoop are sampled live; software changes them only while not in TRANSMIT, and mid-frame changes are undefined.
REQ-026 In 32-bit mode pixelIndex[1:0] is always 0.
REQ-027 All outputs are registered and never driven combinationally from inputs.

Reset
REQ-028 reset takes priority over all inputs; next cycle: GAP, gap counter 0, state=`ENUM_STATE_RESET, pixelIndex=0, pixelBitIndex=23, bitPatternIndex=0, streamSyncOf=0.
REQ-029 reset asserted mid-frame truncates the frame with no streamSyncOf pulse.

Configuration
REQ-030 Macro ANTON_NEOPIXEL_FRAME_COUNT_EN, when defined, adds output frameCount (16 bits, reset 0), which increments with wrap on each streamSyncOf.
REQ-031 Without ANTON_NEOPIXEL_FRAME_COUNT_EN the frameCount port and its logic are absent and all other behaviour is identical.

Verification
REQ-032 RESET_DELAY=400, run=1, loop=0, release reset, start pulse at cycle 500 -> state TRANSMIT at cycle 501 with pixelIndex=0, pixelBitIndex=23.
REQ-033 8-bit mode, regPixelMax=2 -> 576 TRANSMIT cycles, pixelIndex 0,1,2, a single streamSyncOf on the 576th cycle, then 400 GAP cycles and IDLE.
REQ-034 32-bit mode, regPixelMax=7, loop=1 -> pixelIndex 0 then 4, 384 TRANSMIT cycles, exactly 400 gap cycles, then automatic restart.
REQ-035 Drop run at pixel 1, bit 10 -> state RESET next cycle, no streamSyncOf, indices at 0/23/0; re-raise run with a start pulse -> TRANSMIT only after 400 gap cycles.
REQ-036 regPixelMax above BUFFER_END -> frame ends at pixelIndex=BUFFER_END; with ANTON_NEOPIXEL_FRAME_COUNT_EN, frameCount goes 0xFFFF->0 on the 65536th frame.
